// File: rtl/obi_arb_pkg.sv
// Shared constants and the round-robin selection helper for the OBI arbiter.
package obi_arb_pkg;

  localparam int OBI_DATA_W  = 32;
  localparam int OBI_ADDR_W  = 32;
  localparam int OBI_BE_W    = 4;

  // Widest request vector rr_select can scan; NUM_MASTERS must not exceed it.
  localparam int MAX_MASTERS = 32;

  // First requester at or after ptr (mod n). Returns 0 when nobody requests.
  // n is passed explicitly because the request vector is zero-extended to MAX_MASTERS.
  function automatic int rr_select(input logic [MAX_MASTERS-1:0] req, input int ptr, input int n);
    int sel;
    int idx;
    sel = 0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int i = MAX_MASTERS - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = (ptr + i) % n;
        if (req[idx[$clog2(MAX_MASTERS)-1:0]]) sel = idx;
        else sel = sel;
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/obi_rr_arbiter_if.sv
// Downstream OBI request and response channels of the arbiter.
interface obi_req_if;
  import obi_arb_pkg::*;
  logic                  req;
  logic                  we;
  logic [OBI_BE_W-1:0]   be;
  logic [OBI_ADDR_W-1:0] addr;
  logic [OBI_DATA_W-1:0] wdata;
  logic                  gnt;

  modport master (output req, we, be, addr, wdata, input gnt);
  modport slave  (input req, we, be, addr, wdata, output gnt);
endinterface

interface obi_rsp_if;
  import obi_arb_pkg::*;
  logic                  rvalid;
  logic [OBI_DATA_W-1:0] rdata;

  // The arbiter receives responses, the memory produces them.
  modport slave  (input rvalid, rdata);
  modport master (output rvalid, rdata);
endinterface

// File: rtl/obi_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered transactions.
module obi_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pushes into a full FIFO and pops from an empty one are ignored.
  always_comb begin
    push_ok_s = push_i & ~full_o;
    pop_ok_s  = pop_i & ~empty_o;
    if (push_ok_s) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    else           wr_ptr_d = wr_ptr_q;
    if (pop_ok_s)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    else           rd_ptr_d = rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok_s) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI memory port among NUM_MASTERS requesters.
// Zero added latency on request and response paths; responses return in order
// via an ID FIFO. Define OBI_ARB_PERF_CNT_EN to add per-master grant counters.
module obi_rr_arbiter
  import obi_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [OBI_BE_W*NUM_MASTERS-1:0]   m_be_i,
  input  logic [OBI_ADDR_W*NUM_MASTERS-1:0] m_addr_i,
  input  logic [OBI_DATA_W*NUM_MASTERS-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]            m_gnt_o,
  output logic [NUM_MASTERS-1:0]            m_rvalid_o,
  output logic [OBI_DATA_W*NUM_MASTERS-1:0] m_rdata_o,
  obi_req_if.master                         mem_req,
  obi_rsp_if.slave                          mem_rsp
`ifdef OBI_ARB_PERF_CNT_EN
  ,
  output logic [32*NUM_MASTERS-1:0]         grant_cnt_o
`endif
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [MAX_MASTERS-1:0] req_vec_s;
  logic [IDX_W-1:0]       sel_s, head_s;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   req_ok_s, hs_s, rsp_ok_s;
  logic                   full_s, empty_s;
  logic [CNT_W-1:0]       fifo_count_unused_s;

  // Selection, next round-robin pointer and handshake qualification.
  // Reset gates the request so nothing leaves the arbiter while rst_ni is low.
  always_comb begin
    req_vec_s = '0;
    req_vec_s[NUM_MASTERS-1:0] = m_req_i;
    sel_s = IDX_W'(rr_select(req_vec_s, int'(rr_ptr_q), NUM_MASTERS));
    if (int'(sel_s) == NUM_MASTERS - 1) rr_ptr_d = '0;
    else                                rr_ptr_d = sel_s + 1'b1;
    req_ok_s = rst_ni & (|m_req_i) & ~full_s;
    hs_s     = req_ok_s & mem_req.gnt;
    rsp_ok_s = mem_rsp.rvalid & ~empty_s;
  end

  // Forward the selected master's fields downstream; all-zero when idle.
  always_comb begin
    mem_req.req = req_ok_s;
    if (req_ok_s) begin
      mem_req.we    = m_we_i[sel_s];
      mem_req.be    = m_be_i[OBI_BE_W*int'(sel_s) +: OBI_BE_W];
      mem_req.addr  = m_addr_i[OBI_ADDR_W*int'(sel_s) +: OBI_ADDR_W];
      mem_req.wdata = m_wdata_i[OBI_DATA_W*int'(sel_s) +: OBI_DATA_W];
    end else begin
      mem_req.we    = 1'b0;
      mem_req.be    = '0;
      mem_req.addr  = '0;
      mem_req.wdata = '0;
    end
  end

  // One-hot grant back to the selected master; response routed to the FIFO head.
  // A stray rvalid with no outstanding ID is dropped.
  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    if (hs_s) m_gnt_o[sel_s] = 1'b1;
    else      m_gnt_o = '0;
    if (rsp_ok_s) begin
      m_rvalid_o[head_s] = 1'b1;
      m_rdata_o[OBI_DATA_W*int'(head_s) +: OBI_DATA_W] = mem_rsp.rdata;
    end else begin
      m_rvalid_o = '0;
    end
  end

  // Round-robin pointer moves past the winner only on an accepted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rr_ptr_q <= '0;
    else if (hs_s) rr_ptr_q <= rr_ptr_d;
    else           rr_ptr_q <= rr_ptr_q;
  end

  // Full blocks new requests even when a pop happens in the same cycle,
  // since full_s comes from registered occupancy. Occupancy itself is unused here.
  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs_s),
    .data_i  (sel_s),
    .pop_i   (rsp_ok_s),
    .data_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (fifo_count_unused_s)
  );

`ifdef OBI_ARB_PERF_CNT_EN
  logic [32*NUM_MASTERS-1:0] grant_cnt_q;

  // Count accepted requests per master; wraps naturally at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) grant_cnt_q <= '0;
    else if (hs_s) grant_cnt_q[32*int'(sel_s) +: 32] <= grant_cnt_q[32*int'(sel_s) +: 32] + 32'd1;
    else grant_cnt_q <= grant_cnt_q;
  end

  assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed self-checking bench for obi_rr_arbiter with a 1-cycle-latency RAM slave.
module tb_obi_rr_arbiter;
  import obi_arb_pkg::*;

  localparam int NM = 2;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_req, m_we, m_gnt, m_rvalid;
  logic [4*NM-1:0]  m_be;
  logic [32*NM-1:0] m_addr, m_wdata, m_rdata;
`ifdef OBI_ARB_PERF_CNT_EN
  logic [32*NM-1:0] grant_cnt;
`endif

  obi_req_if mem_req ();
  obi_rsp_if mem_rsp ();

  logic        gnt_en, hold_rsp, man_mode, man_rvalid, expect_stray;
  logic [31:0] man_rdata;
  logic        slv_rvalid;
  logic [31:0] slv_rdata;
  logic [31:0] ram [256];
  logic [31:0] rsp_q [$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  assign mem_req.gnt    = gnt_en;
  assign mem_rsp.rvalid = man_mode ? man_rvalid : slv_rvalid;
  assign mem_rsp.rdata  = man_mode ? man_rdata  : slv_rdata;

  obi_rr_arbiter #(.NUM_MASTERS(NM), .MAX_OUTSTANDING(MO)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .m_req_i    (m_req),
    .m_we_i     (m_we),
    .m_be_i     (m_be),
    .m_addr_i   (m_addr),
    .m_wdata_i  (m_wdata),
    .m_gnt_o    (m_gnt),
    .m_rvalid_o (m_rvalid),
    .m_rdata_o  (m_rdata),
    .mem_req    (mem_req),
    .mem_rsp    (mem_rsp)
`ifdef OBI_ARB_PERF_CNT_EN
    ,
    .grant_cnt_o (grant_cnt)
`endif
  );

  // RAM slave: one response per handshake, presented the cycle after, in order.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q.delete();
      slv_rvalid <= 1'b0;
      slv_rdata  <= 32'h0;
      for (int i = 0; i < 256; i++) ram[i] <= 32'h1000_0000 + i;
    end else begin
      if (slv_rvalid && !man_mode) void'(rsp_q.pop_front());
      if (mem_req.req && mem_req.gnt && !man_mode) begin
        if (mem_req.we) begin
          for (int b = 0; b < 4; b++)
            if (mem_req.be[b]) ram[mem_req.addr[9:2]][8*b +: 8] <= mem_req.wdata[8*b +: 8];
          rsp_q.push_back(32'h0);
        end else begin
          rsp_q.push_back(ram[mem_req.addr[9:2]]);
        end
      end
      slv_rvalid <= !hold_rsp && (rsp_q.size() > 0);
      slv_rdata  <= (rsp_q.size() > 0) ? rsp_q[0] : 32'h0;
    end
  end

  // Protocol check: rvalid with no outstanding ID, except where injected on purpose.
  always @(posedge clk) begin
    assert (!(rst_n && !expect_stray && mem_rsp.rvalid && dut.u_fifo.empty_o))
      else $error("FAIL stray_rvalid: rvalid=1 with empty ID FIFO, required no rvalid");
  end

  task automatic set_m(input int k, input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
    m_we[k] = we;
    m_be[4*k +: 4] = be;
    m_addr[32*k +: 32] = addr;
    m_wdata[32*k +: 32] = wdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    m_req = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    m_req = 2'b11;
    set_m(0, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
    set_m(1, 1'b0, 4'hF, 32'h0000_0200, 32'h0);
    #2;
    chk_cnt++; if (mem_req.req !== 1'b0) $display("FAIL rst_req: got %b want 0", mem_req.req); else pass_cnt++;
    chk_cnt++; if (m_gnt !== 2'b00) $display("FAIL rst_gnt: got %b want 00", m_gnt); else pass_cnt++;
    chk_cnt++; if (m_rvalid !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", m_rvalid); else pass_cnt++;
    chk_cnt++; if (m_rdata !== 64'h0) $display("FAIL rst_rdata: got %h want 0", m_rdata); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    m_req = 2'b00;
    #1;
    chk_cnt++; if (mem_req.req !== 1'b0) $display("FAIL idle_req: got %b want 0", mem_req.req); else pass_cnt++;
    chk_cnt++; if (mem_req.addr !== 32'h0) $display("FAIL idle_addr: got %h want 0", mem_req.addr); else pass_cnt++;
  endtask

  task automatic test_single();
    @(negedge clk);
    m_req = 2'b01;
    set_m(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    #1;
    chk_cnt++; if (mem_req.req !== 1'b1) $display("FAIL single_req: got %b want 1", mem_req.req); else pass_cnt++;
    chk_cnt++; if (m_gnt !== 2'b01) $display("FAIL single_gnt: got %b want 01", m_gnt); else pass_cnt++;
    chk_cnt++; if (mem_req.addr !== 32'h10) $display("FAIL single_addr: got %h want 10", mem_req.addr); else pass_cnt++;
    @(negedge clk);
    m_req = 2'b00;
    #1;
    chk_cnt++; if (m_rvalid !== 2'b01) $display("FAIL single_rvalid: got %b want 01", m_rvalid); else pass_cnt++;
    chk_cnt++; if (m_rdata !== {32'h0, 32'h1000_0004}) $display("FAIL single_rdata: got %h want 0000000010000004", m_rdata); else pass_cnt++;
    @(negedge clk);
    #1;
    chk_cnt++; if (m_rvalid !== 2'b00) $display("FAIL single_done: got %b want 00", m_rvalid); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [31:0] a0 [5] = '{32'h40, 32'h44, 32'h44, 32'h48, 32'h48};
    logic [31:0] a1 [5] = '{32'h80, 32'h80, 32'h84, 32'h84, 32'h88};
    logic [1:0]  eg [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [31:0] ea [5] = '{32'h40, 32'h80, 32'h44, 32'h84, 32'h0};
    logic [1:0]  ev [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [63:0] ed [5] = '{64'h0, {32'h0, 32'h1000_0010}, {32'h1000_0020, 32'h0},
                            {32'h0, 32'h1000_0011}, {32'h1000_0021, 32'h0}};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      m_req = (c < 4) ? 2'b11 : 2'b00;
      set_m(0, 1'b0, 4'hF, a0[c], 32'h0);
      set_m(1, 1'b0, 4'hF, a1[c], 32'h0);
      #1;
      chk_cnt++; if (m_gnt !== eg[c]) $display("FAIL rr_gnt[%0d]: got %b want %b", c, m_gnt, eg[c]); else pass_cnt++;
      chk_cnt++; if (mem_req.addr !== ea[c]) $display("FAIL rr_addr[%0d]: got %h want %h", c, mem_req.addr, ea[c]); else pass_cnt++;
      chk_cnt++; if (m_rvalid !== ev[c]) $display("FAIL rr_rvalid[%0d]: got %b want %b", c, m_rvalid, ev[c]); else pass_cnt++;
      chk_cnt++; if (m_rdata !== ed[c]) $display("FAIL rr_rdata[%0d]: got %h want %h", c, m_rdata, ed[c]); else pass_cnt++;
    end
    @(negedge clk);
    #1;
    chk_cnt++; if (m_rvalid !== 2'b00) $display("FAIL rr_done: got %b want 00", m_rvalid); else pass_cnt++;
  endtask

  task automatic test_write_merge();
    @(negedge clk);
    m_req = 2'b10;
    set_m(1, 1'b1, 4'b0011, 32'h0000_0020, 32'hAABB_CCDD);
    #1;
    chk_cnt++; if (m_gnt !== 2'b10) $display("FAIL wr_gnt: got %b want 10", m_gnt); else pass_cnt++;
    chk_cnt++; if ({mem_req.we, mem_req.be} !== 5'b1_0011) $display("FAIL wr_we_be: got %b want 10011", {mem_req.we, mem_req.be}); else pass_cnt++;
    chk_cnt++; if (mem_req.wdata !== 32'hAABB_CCDD) $display("FAIL wr_wdata: got %h want aabbccdd", mem_req.wdata); else pass_cnt++;
    @(negedge clk);
    m_req = 2'b01;
    set_m(1, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
    #1;
    chk_cnt++; if (m_rvalid !== 2'b10) $display("FAIL wr_rvalid: got %b want 10", m_rvalid); else pass_cnt++;
    chk_cnt++; if (m_gnt !== 2'b01) $display("FAIL rd_gnt: got %b want 01", m_gnt); else pass_cnt++;
    @(negedge clk);
    m_req = 2'b00;
    #1;
    chk_cnt++; if (m_rvalid !== 2'b01) $display("FAIL rd_rvalid: got %b want 01", m_rvalid); else pass_cnt++;
    chk_cnt++; if (m_rdata !== {32'h0, 32'h1000_CCDD}) $display("FAIL rd_merge: got %h want 000000001000ccdd", m_rdata); else pass_cnt++;
  endtask

  task automatic test_full();
    do_reset();
    hold_rsp = 1'b1;
    @(negedge clk);
    m_req = 2'b01;
    set_m(0, 1'b0, 4'hF, 32'h0, 32'h0);
    #1;
    chk_cnt++; if (m_gnt !== 2'b01) $display("FAIL full_gnt0: got %b want 01", m_gnt); else pass_cnt++;
    @(negedge clk);
    set_m(0, 1'b0, 4'hF, 32'h4, 32'h0);
    #1;
    chk_cnt++; if (m_gnt !== 2'b01) $display("FAIL full_gnt1: got %b want 01", m_gnt); else pass_cnt++;
    @(negedge clk);
    set_m(0, 1'b0, 4'hF, 32'h8, 32'h0);
    hold_rsp = 1'b0;
    #1;
    chk_cnt++; if ({mem_req.req, m_gnt} !== 3'b000) $display("FAIL full_block: got req/gnt %b want 000", {mem_req.req, m_gnt}); else pass_cnt++;
    @(negedge clk);
    #1;
    chk_cnt++; if ({mem_req.req, m_gnt} !== 3'b000) $display("FAIL full_nobypass: got req/gnt %b want 000", {mem_req.req, m_gnt}); else pass_cnt++;
    chk_cnt++; if (m_rdata !== {32'h0, 32'h1000_0000} || m_rvalid !== 2'b01) $display("FAIL full_rsp0: got %b/%h want 01/0000000010000000", m_rvalid, m_rdata); else pass_cnt++;
    @(negedge clk);
    #1;
    chk_cnt++; if (m_gnt !== 2'b01) $display("FAIL full_regnt: got %b want 01", m_gnt); else pass_cnt++;
    chk_cnt++; if (m_rdata !== {32'h0, 32'h1000_0001} || m_rvalid !== 2'b01) $display("FAIL full_rsp1: got %b/%h want 01/0000000010000001", m_rvalid, m_rdata); else pass_cnt++;
    @(negedge clk);
    m_req = 2'b00;
    #1;
    chk_cnt++; if (m_rdata !== {32'h0, 32'h1000_0002} || m_rvalid !== 2'b01) $display("FAIL full_rsp2: got %b/%h want 01/0000000010000002", m_rvalid, m_rdata); else pass_cnt++;
    @(negedge clk);
    #1;
    chk_cnt++; if (m_rvalid !== 2'b00) $display("FAIL full_done: got %b want 00", m_rvalid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    hold_rsp = 1'b1;
    @(negedge clk);
    m_req = 2'b01;
    set_m(0, 1'b0, 4'hF, 32'h0, 32'h0);
    @(negedge clk);
    set_m(0, 1'b0, 4'hF, 32'h4, 32'h0);
    @(negedge clk);
    chk_cnt++; if (dut.u_fifo.count_o !== 2'd2) $display("FAIL mid_outstanding: got %0d want 2", dut.u_fifo.count_o); else pass_cnt++;
    m_req = 2'b11;
    man_mode = 1'b1;
    man_rvalid = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if ({mem_req.req, m_gnt, m_rvalid} !== 5'b0) $display("FAIL mid_outs: got %b want 00000", {mem_req.req, m_gnt, m_rvalid}); else pass_cnt++;
    chk_cnt++; if (m_rdata !== 64'h0) $display("FAIL mid_rdata: got %h want 0", m_rdata); else pass_cnt++;
    chk_cnt++; if (dut.u_fifo.empty_o !== 1'b1 || dut.rr_ptr_q !== 1'b0) $display("FAIL mid_state: got empty=%b ptr=%b want 1/0", dut.u_fifo.empty_o, dut.rr_ptr_q); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    m_req = 2'b00;
    expect_stray = 1'b1;
    #1;
    chk_cnt++; if (m_rvalid !== 2'b00 || m_rdata !== 64'h0) $display("FAIL stray_drop: got %b/%h want 00/0", m_rvalid, m_rdata); else pass_cnt++;
    @(negedge clk);
    expect_stray = 1'b0;
    man_rvalid = 1'b0;
    m_req = 2'b11;
    set_m(1, 1'b0, 4'hF, 32'h4, 32'h0);
    #1;
    chk_cnt++; if (m_gnt !== 2'b01) $display("FAIL post_rst_gnt: got %b want 01", m_gnt); else pass_cnt++;
    @(negedge clk);
    m_req = 2'b00;
    man_rvalid = 1'b1;
    man_rdata = 32'h1234_5678;
    #1;
    chk_cnt++; if (m_rvalid !== 2'b01 || m_rdata !== {32'h0, 32'h1234_5678}) $display("FAIL post_rst_rsp: got %b/%h want 01/0000000012345678", m_rvalid, m_rdata); else pass_cnt++;
    @(negedge clk);
    man_rvalid = 1'b0;
    man_mode = 1'b0;
    hold_rsp = 1'b0;
  endtask

`ifdef OBI_ARB_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    #1;
    chk_cnt++; if (grant_cnt !== 64'h0) $display("FAIL cnt_reset: got %h want 0", grant_cnt); else pass_cnt++;
    set_m(0, 1'b0, 4'hF, 32'h0, 32'h0);
    set_m(1, 1'b0, 4'hF, 32'h4, 32'h0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      m_req = (c < 5) ? 2'b01 : 2'b10;
    end
    @(negedge clk);
    m_req = 2'b00;
    @(negedge clk);
    #1;
    chk_cnt++; if (grant_cnt !== {32'd3, 32'd5}) $display("FAIL cnt_value: got %h want 0000000300000005", grant_cnt); else pass_cnt++;
  endtask
`endif

  initial begin
    m_req = '0;
    m_we = '0;
    m_be = '0;
    m_addr = '0;
    m_wdata = '0;
    gnt_en = 1'b1;
    hold_rsp = 1'b0;
    man_mode = 1'b0;
    man_rvalid = 1'b0;
    man_rdata = 32'h0;
    expect_stray = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_write_merge();
    test_full();
    test_reset_mid();
`ifdef OBI_ARB_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
